// File: rtl/seq_display_ctrl_n_pkg.sv
// Shared types and helpers for the sequence-display controller.
// State encodings stay as legacy 2-bit constants so the enum is bit-compatible.
package seq_disp_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SHOW = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      SHOW = ST_SHOW,
      GAP  = ST_GAP,
      FIN  = ST_FIN
   } state_t;

   localparam int unsigned DIGIT_BLANK = 0;

   // On-time for a sequence of `len` digits; the reduction never wraps below zero.
   function automatic logic [63:0] ontime(input logic [63:0] len,
                                          input logic [63:0] base,
                                          input logic [63:0] step,
                                          input logic [63:0] floor_t);
      logic [63:0] red;
      logic [63:0] res;
      red = (len == 64'd0) ? 64'd0 : step * (len - 64'd1);
      if (red >= base)
         res = floor_t;
      else if ((base - red) < floor_t)
         res = floor_t;
      else
         res = base - red;
      return res;
   endfunction

endpackage

// File: rtl/seq_display_ctrl_n_if.sv
// Game-FSM <-> display-controller bus. Adds `pause` when SEQ_DISP_PAUSE_EN is defined.
interface seq_display_ctrl_n_if #(
   parameter int unsigned DIGIT_W = 4,
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned LVL_W   = 4
);
   localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic                       start;
   logic                       abort;
   logic [LVL_W-1:0]           level;
   logic [MAX_LEN*DIGIT_W-1:0] seq;
`ifdef SEQ_DISP_PAUSE_EN
   logic                       pause;
`endif
   logic [DIGIT_W-1:0]         digit_out;
   logic                       digit_valid;
   logic [IDX_W-1:0]           digit_idx;
   logic                       busy;
   logic                       done;

   modport master (
      output start, abort, level, seq,
`ifdef SEQ_DISP_PAUSE_EN
      output pause,
`endif
      input  digit_out, digit_valid, digit_idx, busy, done
   );

   modport slave (
      input  start, abort, level, seq,
`ifdef SEQ_DISP_PAUSE_EN
      input  pause,
`endif
      output digit_out, digit_valid, digit_idx, busy, done
   );

endinterface

// File: rtl/seq_display_ctrl_n_tick_timer.sv
// Loadable down-counter; expire is high on the last enabled cycle of a loaded interval.
module tick_timer #(
   parameter int unsigned TICK_W = 26
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              en,
   input  logic [TICK_W-1:0] load_val,
   output logic              expire
);

   logic [TICK_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && (count != '0))
         count <= count - TICK_W'(1);
   end

   assign expire = en && (count == '0);

endmodule

// File: rtl/seq_display_ctrl_n.sv
// Sequence-display controller: plays back the first `level` digits of a packed sequence.
// Optional macro SEQ_DISP_PAUSE_EN adds a pause input that freezes playback.
module seq_display_ctrl_n
   import seq_disp_pkg::*;
#(
   parameter int unsigned DIGIT_W    = 4,
   parameter int unsigned MAX_LEN    = 8,
   parameter int unsigned LVL_W      = 4,
   parameter int unsigned TICK_W     = 26,
   parameter int unsigned BASE_TICKS = 50_000_000,
   parameter int unsigned STEP_TICKS = 5_000_000,
   parameter int unsigned MIN_TICKS  = 10_000_000,
   parameter int unsigned GAP_TICKS  = 5_000_000
) (
   input logic                 clk,
   input logic                 rst,
   seq_display_ctrl_n_if.slave bus
);

   localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
   localparam int unsigned SEQ_W = MAX_LEN * DIGIT_W;

   state_t             state_q, state_d;
   logic [SEQ_W-1:0]   seq_q;
   logic [LEN_W-1:0]   len_q;
   logic [TICK_W-1:0]  ton_q;
   logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
   logic [DIGIT_W-1:0] dout_q, dout_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [LEN_W-1:0]   len_eff;
   logic [TICK_W-1:0]  ton_eff;
   logic               latch;
   logic               t_load, t_en, t_expire;
   logic [TICK_W-1:0]  t_val;
   logic               pause_i;
   logic               is_last;

`ifdef SEQ_DISP_PAUSE_EN
   assign pause_i = bus.pause;
`else
   assign pause_i = 1'b0;
`endif

   function automatic logic [DIGIT_W-1:0] pick(input logic [SEQ_W-1:0] s,
                                               input logic [IDX_W-1:0] i);
      return s[(MAX_LEN - 1 - 32'(i)) * DIGIT_W +: DIGIT_W];
   endfunction

   function automatic logic [TICK_W-1:0] dec(input logic [TICK_W-1:0] x);
      return (x == '0) ? '0 : x - TICK_W'(1);
   endfunction

   assign len_eff = (32'(bus.level) > MAX_LEN) ? LEN_W'(MAX_LEN) : LEN_W'(bus.level);
   assign ton_eff = TICK_W'(ontime(64'(len_eff), 64'(BASE_TICKS),
                                   64'(STEP_TICKS), 64'(MIN_TICKS)));
   assign is_last = ((32'(idx_q) + 32'd1) == 32'(len_q));
   assign idx_nxt = idx_q + IDX_W'(1);
   assign t_en    = ((state_q == SHOW) || (state_q == GAP)) && !pause_i;

   tick_timer #(.TICK_W(TICK_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (t_load),
      .en       (t_en),
      .load_val (t_val),
      .expire   (t_expire)
   );

   // Outputs are computed one cycle ahead so every port comes straight from a flop.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      latch   = 1'b0;
      t_load  = 1'b0;
      t_val   = '0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               latch = 1'b1;
               idx_d = '0;
               if (len_eff == '0) begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d = SHOW;
                  valid_d = 1'b1;
                  dout_d  = pick(bus.seq, '0);
                  busy_d  = 1'b1;
                  t_load  = 1'b1;
                  t_val   = dec(ton_eff);
               end
            end
         end
         SHOW, GAP: begin
            if (bus.abort) begin
               state_d = IDLE;
               idx_d   = '0;
               valid_d = 1'b0;
               dout_d  = DIGIT_W'(DIGIT_BLANK);
               busy_d  = 1'b0;
            end else if (t_expire) begin
               if ((state_q == SHOW) && is_last) begin
                  state_d = FIN;
                  idx_d   = '0;
                  valid_d = 1'b0;
                  dout_d  = DIGIT_W'(DIGIT_BLANK);
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else if ((state_q == SHOW) && (GAP_TICKS != 0)) begin
                  state_d = GAP;
                  valid_d = 1'b0;
                  dout_d  = DIGIT_W'(DIGIT_BLANK);
                  t_load  = 1'b1;
                  t_val   = TICK_W'(GAP_TICKS - 1);
               end else begin
                  state_d = SHOW;
                  idx_d   = idx_nxt;
                  valid_d = 1'b1;
                  dout_d  = pick(seq_q, idx_nxt);
                  t_load  = 1'b1;
                  t_val   = dec(ton_q);
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         seq_q   <= '0;
         len_q   <= '0;
         ton_q   <= '0;
         idx_q   <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         if (latch) begin
            seq_q <= bus.seq;
            len_q <= len_eff;
            ton_q <= ton_eff;
         end
      end
   end

   assign bus.digit_out   = dout_q;
   assign bus.digit_valid = valid_q;
   assign bus.digit_idx   = idx_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;

endmodule

// File: doc/seq_display_ctrl_n.md
Name: seq_display_ctrl_n

Overview:
- Parametrised sequence-display controller for the memory game. Plays back the first `level` digits of a packed sequence one at a time.
- Each digit is held for a level-dependent on-time, then a blank gap follows.
- The tick timer is internal, so no external timer handshake is needed.
- Sits between the game FSM (start/level/sequence) and the 7-segment digit driver (digit_out/digit_valid).

Parameters:
- DIGIT_W, 4, bits per sequence digit.
- MAX_LEN, 8, maximum digits per sequence.
- LVL_W, 4, width of level input.
- TICK_W, 26, width of internal tick counter.
- BASE_TICKS, 50_000_000, on-time (cycles) at level 1.
- STEP_TICKS, 5_000_000, on-time reduction per level above 1.
- MIN_TICKS, 10_000_000, on-time floor.
- GAP_TICKS, 5_000_000, blank cycles between digits; 0 = no gap.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous, active-low reset.
- start, input, 1, one-cycle request to begin playback.
- abort, input, 1, cancel playback.
- level, input, LVL_W, number of digits to show.
- seq, input, MAX_LEN*DIGIT_W, packed sequence; digit 0 in the MSBs.
- digit_out, output, DIGIT_W, current digit; 0 when not valid.
- digit_valid, output, 1, digit_out is to be displayed.
- digit_idx, output, clog2(MAX_LEN), index of digit shown.
- busy, output, 1, playback in progress.
- done, output, 1, one-cycle pulse on completion.

Behaviour:
- Reset (rst=0 at posedge) values:
  - state=IDLE.
  - digit_out=0, digit_valid=0, digit_idx=0, busy=0, done=0.
  - Tick counter=0.
  - Reset mid-playback discards everything, with no done pulse.
- States: IDLE, SHOW, GAP, FIN.
- IDLE:
  - start=1 latches seq, effective length L=min(level, MAX_LEN) and on-time T.
  - T = max(BASE_TICKS - STEP_TICKS*(L-1), MIN_TICKS). Compute in TICK_W+LVL_W bits; no negative wrap, so an underflow clamps to MIN_TICKS.
  - If L=0: go to FIN.
  - Otherwise: go to SHOW with idx=0.
  - busy rises on the cycle after start.
- SHOW:
  - digit_valid=1 and digit_out = seq_latched[(MAX_LEN-1-idx)*DIGIT_W +: DIGIT_W].
  - Lasts exactly T cycles.
  - Then, if idx=L-1: go to FIN.
  - Else if GAP_TICKS=0: go to SHOW with idx+1.
  - Else: go to GAP.
- GAP:
  - digit_valid=0 and digit_out=0 for exactly GAP_TICKS cycles.
  - Then go to SHOW with idx+1.
- FIN: done=1 and busy=0 for one cycle, then IDLE.
- Total busy cycles = L*T + (L-1)*GAP_TICKS. done is asserted in the following cycle.
- start while not IDLE is ignored. seq and level changes during playback have no effect.
- abort=1 in SHOW or GAP:
  - Next cycle: IDLE, digit_valid=0, busy=0, no done.
  - abort takes priority over tick expiry in the same cycle.
- abort in IDLE with start=1 in the same cycle: start wins.
- All outputs are registered.

Optional Feature:
- Macro: SEQ_DISP_PAUSE_EN.
- When defined:
  - Extra input port pause (1 bit).
  - While pause=1 in SHOW or GAP, the tick counter and state freeze and the outputs hold.
  - abort still acts while paused.
- When undefined: no pause port; playback timing is fixed.

Decomposition:
- Shared package seq_disp_pkg holds:
  - State enum {IDLE, SHOW, GAP, FIN}.
  - DIGIT_BLANK constant (0).
  - on-time function ontime(level) with clamp logic.
- One natural sub-module, tick_timer: a loadable down-counter with load, en and expire outputs, reused for both SHOW and GAP.

Test Plan:
- Bench params DIGIT_W=4, MAX_LEN=5, BASE=10, STEP=2, MIN=4, GAP=2.
- Test 1: level=5, seq=20'h79BCC, start pulse -> digits 7,9,B,C,C, each valid for 4 cycles with 2-cycle gaps; busy for 28 cycles; done pulses once.
- Test 2: level=1, seq=20'h3xxxx -> digit 3 valid for 10 cycles with no gap; done on the next cycle.
- Test 3: level=0 -> no digit_valid; done pulses 1 cycle after start; busy never 1.
- Test 4: level=7 -> clamped to L=5, T=4; same waveform as test 1.
- Test 5: abort during the 3rd digit; start again during the 2nd digit -> abort gives IDLE next cycle with no done; a second start while busy is ignored.
- Test 6: rst=0 mid-GAP -> all outputs 0 at the next edge. With SEQ_DISP_PAUSE_EN, pause=1 for 6 cycles in SHOW extends that digit to 10 cycles.
